// File: rtl/opll_pkg.sv
// Shared types and timing defaults for the OPLL write sequencer.
// Contents: FSM state enum, FIFO entry struct, default recovery waits.
// The chip field is sized for the largest supported chip count (8).
package opll_pkg;

  localparam int OPLL_ADDR_WAIT = 12;
  localparam int OPLL_DATA_WAIT = 84;
  localparam int OPLL_CHIP_W    = 3;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    WAIT
  } opll_state_e;

  typedef struct packed {
    logic [OPLL_CHIP_W-1:0] chip;
    logic                   a0;
    logic [7:0]             data;
  } opll_entry_t;

endpackage

// File: rtl/opll_wr_fifo.sv
// Register-based synchronous FIFO with occupancy output.
// Latency: a push is visible at head_dat/level one cycle after the accepting edge.
// Backpressure: push_rdy = level != DEPTH from the registered level; pushes while full are dropped.
// Ports: push_vld/push_dat/push_rdy (write side), pop/head_dat/empty (read side), level.
module opll_wr_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  output logic             push_rdy,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign push_rdy = (level != LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push_vld && push_rdy;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers are exactly AW bits wide, so wrap modulo DEPTH is implicit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/opll_write_sequencer.sv
// Buffers host OPLL register writes and replays them on CS_n/WR_n/A0/D with chip recovery waits.
// Latency: write accepted at edge N reaches SETUP after edge N+1; bus cycle = WR_PULSE + 3 + wait.
// Backpressure: o_ready low while the FIFO holds DEPTH entries; host must hold i_valid.
// Ports: i_valid/o_ready/i_a0/i_data/i_chip host side; o_cs_n/o_wr_n/o_a0/o_d chip side;
//        o_busy (FSM active or FIFO non-empty), o_level (FIFO occupancy).
// Optional: define OPLL_WRSEQ_ADDR_SKIP_EN to drop address writes repeating a chip's last address.
module opll_write_sequencer
  import opll_pkg::*;
#(
  parameter  int DEPTH     = 8,
  parameter  int NUM_CHIPS = 1,
  parameter  int WR_PULSE  = 2,
  parameter  int ADDR_WAIT = OPLL_ADDR_WAIT,
  parameter  int DATA_WAIT = OPLL_DATA_WAIT,
  localparam int CW        = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1,
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_a0,
  input  logic [7:0]           i_data,
  input  logic [CW-1:0]        i_chip,
  output logic [NUM_CHIPS-1:0] o_cs_n,
  output logic                 o_wr_n,
  output logic                 o_a0,
  output logic [7:0]           o_d,
  output logic                 o_busy,
  output logic [LW-1:0]        o_level
);

  localparam int MAX_WAIT = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int WCW      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam int PCW      = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;
  localparam logic [OPLL_CHIP_W:0] NCH_L = (OPLL_CHIP_W + 1)'(NUM_CHIPS);

  opll_state_e  state;
  opll_entry_t  push_ent;
  opll_entry_t  head;
  logic         empty;
  logic         pop;
  logic         start;
  logic         skip;
  logic [PCW-1:0] pcnt;
  logic [WCW-1:0] wcnt;
  logic [WCW-1:0] wait_len;

  // Out-of-range chip indices decode to no select at all.
  function automatic logic [NUM_CHIPS-1:0] cs_decode(input logic [OPLL_CHIP_W-1:0] chip);
    cs_decode = '1;
    for (int i = 0; i < NUM_CHIPS; i++) begin
      if (chip == OPLL_CHIP_W'(i)) cs_decode[i] = 1'b0;
    end
  endfunction

  assign push_ent = '{chip: OPLL_CHIP_W'(i_chip), a0: i_a0, data: i_data};

  opll_wr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(opll_entry_t))
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (i_valid),
    .push_dat (push_ent),
    .push_rdy (o_ready),
    .pop      (pop),
    .head_dat (head),
    .empty    (empty),
    .level    (o_level)
  );

  // Skipped entries are popped too but leave the FSM in IDLE.
  assign pop      = (state == IDLE) && !empty;
  assign start    = pop && !skip;
  assign o_busy   = (state != IDLE) || !empty;
  // o_a0 holds the executing entry's a0 from SETUP onwards.
  assign wait_len = o_a0 ? WCW'(DATA_WAIT) : WCW'(ADDR_WAIT);

`ifdef OPLL_WRSEQ_ADDR_SKIP_EN
  logic [7:0]                  last_addr [2**OPLL_CHIP_W];
  logic [2**OPLL_CHIP_W-1:0]   last_vld;
  logic                        in_range;

  assign in_range = ({1'b0, head.chip} < NCH_L);
  assign skip     = in_range && !head.a0 && last_vld[head.chip] &&
                    (last_addr[head.chip] == head.data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_vld <= '0;
      for (int i = 0; i < 2**OPLL_CHIP_W; i++) last_addr[i] <= '0;
    end else if (start && in_range && !head.a0) begin
      last_addr[head.chip] <= head.data;
      last_vld[head.chip]  <= 1'b1;
    end
  end
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      o_cs_n <= '1;
      o_wr_n <= 1'b1;
      o_a0   <= 1'b0;
      o_d    <= '0;
      pcnt   <= '0;
      wcnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            o_cs_n <= cs_decode(head.chip);
            o_a0   <= head.a0;
            o_d    <= head.data;
            state  <= SETUP;
          end
        end
        SETUP: begin
          o_wr_n <= 1'b0;
          pcnt   <= PCW'(WR_PULSE - 1);
          state  <= STROBE;
        end
        STROBE: begin
          if (pcnt == '0) begin
            o_wr_n <= 1'b1;
            state  <= HOLD;
          end else begin
            pcnt <= pcnt - 1'b1;
          end
        end
        HOLD: begin
          o_cs_n <= '1;
          // Counter is loaded with wait-1 so WAIT lasts exactly wait cycles.
          if (wait_len == '0) begin
            state <= IDLE;
          end else begin
            wcnt  <= wait_len - 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (wcnt == '0) state <= IDLE;
          else            wcnt  <= wcnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opll_write_sequencer.sv
module tb_opll_write_sequencer;

  localparam int DEPTH = 8;
  localparam int NCH   = 3;
  localparam int WRP   = 2;
  localparam int AWT   = 12;
  localparam int DWT   = 84;
  localparam int CW    = 2;
  localparam int LW    = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           i_valid = 1'b0;
  logic           i_a0 = 1'b0;
  logic [7:0]     i_data = 8'h00;
  logic [CW-1:0]  i_chip = '0;
  logic           o_ready, o_wr_n, o_a0, o_busy;
  logic [NCH-1:0] o_cs_n;
  logic [7:0]     o_d;
  logic [LW-1:0]  o_level;

  opll_write_sequencer #(
    .DEPTH(DEPTH), .NUM_CHIPS(NCH), .WR_PULSE(WRP), .ADDR_WAIT(AWT), .DATA_WAIT(DWT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_a0(i_a0),
    .i_data(i_data), .i_chip(i_chip), .o_cs_n(o_cs_n), .o_wr_n(o_wr_n), .o_a0(o_a0),
    .o_d(o_d), .o_busy(o_busy), .o_level(o_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A write occupies phases 0..last after it is popped: 0 = select, 1..WRP = strobe,
  // WRP+1 = hold, then the recovery wait; one idle cycle follows before the next pop.
  typedef struct { bit a0; bit [7:0] d; int ch; } wr_t;
  wr_t      q[$];
  wr_t      cur;
  bit       act;
  int       p, last, m_acc;
  bit       m_a0;
  bit [7:0] m_d;
  bit [7:0] la [4];
  bit       lv [4];

  function automatic void mreset();
    q.delete();
    act = 0; p = 0; last = 0; m_a0 = 0; m_d = 0; cur.ch = 0;
    for (int i = 0; i < 4; i++) begin lv[i] = 0; la[i] = 0; end
  endfunction

  function automatic void mstep();
    int  sz;
    wr_t h;
    bit  skip;
    sz = q.size();
    if (act) begin
      if (p == last) act = 0;
      else p++;
    end else if (sz > 0) begin
      h = q.pop_front();
      skip = 0;
`ifdef OPLL_WRSEQ_ADDR_SKIP_EN
      if (!h.a0 && h.ch < NCH && lv[h.ch] && la[h.ch] == h.d) skip = 1;
`endif
      if (!skip) begin
        cur = h; act = 1; p = 0;
        last = WRP + 1 + (h.a0 ? DWT : AWT);
        m_a0 = h.a0; m_d = h.d;
        if (!h.a0 && h.ch < NCH) begin la[h.ch] = h.d; lv[h.ch] = 1; end
      end
    end
    if (i_valid && sz < DEPTH) begin
      q.push_back('{a0: i_a0, d: i_data, ch: int'(i_chip)});
      m_acc++;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mreset();
    else        mstep();
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [NCH-1:0] ecs;
    ecs = '1;
    if (act && p <= WRP + 1 && cur.ch < NCH) ecs[cur.ch] = 1'b0;
    chk("cs_n",  int'(o_cs_n),  int'(ecs));
    chk("wr_n",  int'(o_wr_n),  int'(!(act && p >= 1 && p <= WRP)));
    chk("a0",    int'(o_a0),    int'(m_a0));
    chk("d",     int'(o_d),     int'(m_d));
    chk("level", int'(o_level), q.size());
    chk("ready", int'(o_ready), int'(q.size() < DEPTH));
    chk("busy",  int'(o_busy),  int'(act || q.size() != 0));
  end

  // Strobe monitor: cycle, data and selects at each WR_n falling edge.
  int   fall_t[$];
  int   fall_d[$];
  int   fall_cs[$];
  logic prev_wr = 1'b1;
  always @(negedge clk) begin
    if (prev_wr && !o_wr_n) begin
      fall_t.push_back(cyc);
      fall_d.push_back(int'(o_d));
      fall_cs.push_back(int'(o_cs_n));
    end
    prev_wr = o_wr_n;
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input bit a0, input bit [7:0] d, input int ch);
    int n;
    n = 0;
    i_valid = 1'b1; i_a0 = a0; i_data = d; i_chip = CW'(ch);
    while (!o_ready && n < 2000) begin @(negedge clk); n++; end
    chk("push_wait", int'(o_ready), 1);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while (o_busy && n < lim) begin @(negedge clk); n++; end
    chk("drain_timeout", int'(o_busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, n, b_acc, maxl;
    bit seen;

    repeat (3) @(negedge clk);
    chk("rst_ready", int'(o_ready), 1);
    chk("rst_level", int'(o_level), 0);
    chk("rst_busy",  int'(o_busy), 0);
    chk("rst_cs",    int'(o_cs_n), 7);
    chk("rst_wr",    int'(o_wr_n), 1);
    chk("rst_a0",    int'(o_a0), 0);
    chk("rst_d",     int'(o_d), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single address write: SETUP two cycles after acceptance, 2-cycle strobe, 17-cycle bus cycle.
    push(0, 8'h30, 0);
    chk("t1_level", int'(o_level), 1);
    chk("t1_cs_pre", int'(o_cs_n), 7);
    @(negedge clk);
    chk("t1_cs_setup", int'(o_cs_n), 6);
    chk("t1_wr_setup", int'(o_wr_n), 1);
    chk("t1_d_setup", int'(o_d), 8'h30);
    @(negedge clk); chk("t1_wr_strobe1", int'(o_wr_n), 0);
    @(negedge clk); chk("t1_wr_strobe2", int'(o_wr_n), 0);
    @(negedge clk); chk("t1_wr_hold", int'(o_wr_n), 1); chk("t1_cs_hold", int'(o_cs_n), 6);
    @(negedge clk); chk("t1_cs_wait", int'(o_cs_n), 7);
    repeat (11) @(negedge clk);
    chk("t1_busy_last_wait", int'(o_busy), 1);
    @(negedge clk);
    chk("t1_busy_idle", int'(o_busy), 0);
    chk("t1_d_kept", int'(o_d), 8'h30);

    // Address + data pair, then one more write.
    b = fall_t.size();
    push(0, 8'h10, 0); push(1, 8'h55, 0); push(0, 8'h11, 0);
    drain(400);
    chk("pair_strobes", fall_t.size() - b, 3);
    if (fall_t.size() >= b + 3) begin
      chk("pair_gap_addr", fall_t[b+1] - fall_t[b], 17);
      chk("pair_gap_data", fall_t[b+2] - fall_t[b+1], 89);
      chk("pair_data_d", fall_d[b+1], 8'h55);
    end

    // Multi-chip and out-of-range chip.
    b = fall_t.size();
    push(0, 8'h01, 1); push(0, 8'h02, 0); push(0, 8'h03, 3); push(1, 8'h04, 3); push(0, 8'h05, 0);
    drain(600);
    chk("mc_strobes", fall_t.size() - b, 5);
    if (fall_t.size() >= b + 5) begin
      chk("mc_cs_chip1", fall_cs[b], 5);
      chk("mc_cs_chip0", fall_cs[b+1], 6);
      chk("mc_cs_chip3", fall_cs[b+2], 7);
      chk("mc_gap_oor_addr", fall_t[b+3] - fall_t[b+2], 17);
      chk("mc_gap_oor_data", fall_t[b+4] - fall_t[b+3], 89);
    end

    // FIFO full: hold i_valid until 12 writes are accepted.
    b_acc = m_acc; seen = 0; maxl = 0; n = 0;
    i_valid = 1'b1; i_a0 = 1'b0; i_chip = '0; i_data = 8'h80;
    while (m_acc - b_acc < 12 && n < 500) begin
      @(negedge clk); n++;
      if (!o_ready && !seen) begin
        seen = 1;
        chk("full_accepted_at_drop", m_acc - b_acc, 9);
      end
      if (int'(o_level) > maxl) maxl = int'(o_level);
      i_data = 8'h80 + 8'(m_acc - b_acc);
    end
    i_valid = 1'b0;
    chk("full_ready_dropped", int'(seen), 1);
    chk("full_accepted", m_acc - b_acc, 12);
    drain(600);
    chk("full_max_level", maxl, 8);

    // Reset during a strobe with three writes queued.
    push(0, 8'h40, 0); push(0, 8'h41, 0); push(0, 8'h42, 0); push(0, 8'h43, 0);
    n = 0;
    while (o_wr_n && n < 50) begin @(negedge clk); n++; end
    chk("rst_in_strobe", int'(o_wr_n), 0);
    chk("rst_pre_level", int'(o_level), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_wr", int'(o_wr_n), 1);
    chk("rst_mid_cs", int'(o_cs_n), 7);
    chk("rst_mid_level", int'(o_level), 0);
    chk("rst_mid_busy", int'(o_busy), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    b = fall_t.size();
    repeat (200) @(negedge clk);
    chk("rst_no_residual", fall_t.size() - b, 0);

    // Repeated address to the same chip.
    b = fall_t.size();
    push(0, 8'h20, 0); push(1, 8'h01, 0); push(0, 8'h20, 0); push(1, 8'h02, 0);
    drain(800);
`ifdef OPLL_WRSEQ_ADDR_SKIP_EN
    chk("skip_strobes", fall_t.size() - b, 3);
`else
    chk("skip_strobes", fall_t.size() - b, 4);
`endif

    // Randomized traffic, checked every cycle against the model.
    repeat (2000) begin
      @(negedge clk);
      i_valid = ($urandom_range(0, 9) < 3);
      i_a0    = ($urandom_range(0, 3) == 0);
      i_data  = 8'($urandom_range(0, 3));
      i_chip  = CW'($urandom_range(0, 3));
    end
    i_valid = 1'b0;
    drain(3000);
    chk("final_level", int'(o_level), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
